dm_host_axi_lite_master: RTL and testbench

Byte-stream command bridge that turns debug-host requests into single AXI-Lite transactions. It sits directly upstream of the AXI-Lite-to-debug-module slave bridge. Its byte input comes from the host link, typically a UART receiver, and its response bytes go back to the same link. It parses fixed-format read and write commands, drives exactly one outstanding AXI-Lite transaction at a time, and serialises the response.

---
 rtl/holy_core_pkg.sv | 19 +
 rtl/axi_lite_if.sv | 41 ++++
 rtl/dm_host_axi_lite_master.sv | 156 +++++++++++++++
 tb/tb_dm_host_axi_lite_master.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/holy_core_pkg.sv
// Shared types and constants for the debug-host AXI-Lite bridge.
package holy_core_pkg;

   typedef enum logic [2:0] {
      HOST_IDLE,
      HOST_ADDR,
      HOST_DATA,
      AXI_AW_W,
      AXI_B,
      AXI_AR,
      AXI_R,
      HOST_TX
   } axi_state_host_t;

   localparam logic [7:0] HOST_OP_WRITE   = 8'h01;
   localparam logic [7:0] HOST_OP_READ    = 8'h02;
   localparam logic [7:0] HOST_RESP_BADOP = 8'hFF;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle with master and slave views.
interface axi_lite_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/dm_host_axi_lite_master.sv
// Parses host byte commands into single AXI-Lite reads/writes and streams the response back.
// Handshakes: a beat moves on every clock edge where valid && ready; valids never depend on readies.
module dm_host_axi_lite_master
   import holy_core_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      rx_data_i,
   input  logic            rx_valid_i,
   output logic            rx_ready_o,
   output logic [7:0]      tx_data_o,
   output logic            tx_valid_o,
   input  logic            tx_ready_i,
   axi_lite_if.master      m_axi_lite,
   output axi_state_host_t dbg_state_o
);

   axi_state_host_t state_q;
   logic [1:0]  byte_cnt_q;
   logic [2:0]  tx_idx_q;
   logic [2:0]  tx_last_q;
   logic        is_write_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [39:0] tx_buf_q;
   logic        awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
   logic        tx_valid_q, rx_ready_q;
   logic        rx_fire;

   assign rx_fire = rx_valid_i && rx_ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= HOST_IDLE;
         byte_cnt_q <= '0;
         tx_idx_q   <= '0;
         tx_last_q  <= '0;
         is_write_q <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         tx_buf_q   <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         bready_q   <= 1'b0;
         rready_q   <= 1'b0;
         tx_valid_q <= 1'b0;
         rx_ready_q <= 1'b1;
      end else begin
         case (state_q)
            HOST_IDLE: if (rx_fire) begin
               byte_cnt_q <= '0;
               if (rx_data_i == HOST_OP_WRITE || rx_data_i == HOST_OP_READ) begin
                  is_write_q <= (rx_data_i == HOST_OP_WRITE);
                  state_q    <= HOST_ADDR;
               end else begin
                  tx_buf_q   <= {32'h0, HOST_RESP_BADOP};
                  tx_idx_q   <= '0;
                  tx_last_q  <= 3'd0;
                  tx_valid_q <= 1'b1;
                  rx_ready_q <= 1'b0;
                  state_q    <= HOST_TX;
               end
            end
            HOST_ADDR: if (rx_fire) begin
               // LSB arrives first, so bytes enter at the top and shift down.
               addr_q     <= {rx_data_i, addr_q[31:8]};
               byte_cnt_q <= byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  byte_cnt_q <= '0;
                  if (is_write_q) begin
                     state_q <= HOST_DATA;
                  end else begin
                     arvalid_q  <= 1'b1;
                     rx_ready_q <= 1'b0;
                     state_q    <= AXI_AR;
                  end
               end
            end
            HOST_DATA: if (rx_fire) begin
               data_q     <= {rx_data_i, data_q[31:8]};
               byte_cnt_q <= byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  byte_cnt_q <= '0;
                  awvalid_q  <= 1'b1;
                  wvalid_q   <= 1'b1;
                  rx_ready_q <= 1'b0;
                  state_q    <= AXI_AW_W;
               end
            end
            AXI_AW_W: begin
               // AW and W retire independently; move on once neither is pending.
               awvalid_q <= awvalid_q && !m_axi_lite.awready;
               wvalid_q  <= wvalid_q && !m_axi_lite.wready;
               if ((!awvalid_q || m_axi_lite.awready) && (!wvalid_q || m_axi_lite.wready)) begin
                  bready_q <= 1'b1;
                  state_q  <= AXI_B;
               end
            end
            AXI_B: if (m_axi_lite.bvalid) begin
               bready_q   <= 1'b0;
               tx_buf_q   <= {32'h0, 6'b0, m_axi_lite.bresp};
               tx_idx_q   <= '0;
               tx_last_q  <= 3'd0;
               tx_valid_q <= 1'b1;
               state_q    <= HOST_TX;
            end
            AXI_AR: if (m_axi_lite.arready) begin
               arvalid_q <= 1'b0;
               rready_q  <= 1'b1;
               state_q   <= AXI_R;
            end
            AXI_R: if (m_axi_lite.rvalid) begin
               rready_q   <= 1'b0;
               tx_buf_q   <= {m_axi_lite.rdata[31:0], 6'b0, m_axi_lite.rresp};
               tx_idx_q   <= '0;
               tx_last_q  <= 3'd4;
               tx_valid_q <= 1'b1;
               state_q    <= HOST_TX;
            end
            HOST_TX: if (tx_ready_i) begin
               tx_buf_q <= tx_buf_q >> 8;
               tx_idx_q <= tx_idx_q + 3'd1;
               if (tx_idx_q == tx_last_q) begin
                  tx_idx_q   <= '0;
                  tx_valid_q <= 1'b0;
                  rx_ready_q <= 1'b1;
                  state_q    <= HOST_IDLE;
               end
            end
            default: state_q <= HOST_IDLE;
         endcase
      end
   end

   assign rx_ready_o  = rx_ready_q;
   assign tx_valid_o  = tx_valid_q;
   assign tx_data_o   = tx_buf_q[7:0];
   assign dbg_state_o = state_q;

   assign m_axi_lite.awaddr  = AXI_ADDR_WIDTH'(addr_q);
   assign m_axi_lite.awprot  = 3'b000;
   assign m_axi_lite.awvalid = awvalid_q;
   assign m_axi_lite.wdata   = AXI_DATA_WIDTH'(data_q);
   assign m_axi_lite.wstrb   = '1;
   assign m_axi_lite.wvalid  = wvalid_q;
   assign m_axi_lite.bready  = bready_q;
   assign m_axi_lite.araddr  = AXI_ADDR_WIDTH'(addr_q);
   assign m_axi_lite.arprot  = 3'b000;
   assign m_axi_lite.arvalid = arvalid_q;
   assign m_axi_lite.rready  = rready_q;

endmodule

// File: tb/tb_dm_host_axi_lite_master.sv
// Directed bench: host byte driver, latency-configurable AXI-Lite slave, per-cycle compare against a byte/transaction model.
module tb_dm_host_axi_lite_master;
   import holy_core_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] rx_data_i = 8'h00;
   logic rx_valid_i = 1'b0;
   logic rx_ready_o;
   logic [7:0] tx_data_o;
   logic tx_valid_o;
   logic tx_ready_i;
   axi_state_host_t dbg_state;

   axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

   dm_host_axi_lite_master #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
      .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
      .m_axi_lite(axi), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // model state
   logic [7:0]  exp_tx_q[$];
   logic [31:0] exp_aw_q[$];
   logic [31:0] exp_w_q[$];
   logic [31:0] exp_ar_q[$];
   logic [7:0]  got_tx_q[$];

   // slave configuration
   int aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 1;
   logic [1:0]  cfg_bresp = 2'b00;
   logic [1:0]  cfg_rresp = 2'b00;
   logic [31:0] cfg_rdata = 32'h0;

   int n_aw = 0, n_w = 0, n_ar = 0, valid_cycles = 0;
   logic [31:0] last_awaddr = '0, last_wdata = '0;
   int expect_bus = 0;
   int tx_stall_left = 0;

   // ---------------- slave ----------------
   initial begin
      logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rst_s;
      logic got_aw, got_w, got_ar;
      int cnt_aw, cnt_w, cnt_ar, cnt_b, cnt_r;
      got_aw = 0; got_w = 0; got_ar = 0;
      cnt_aw = 0; cnt_w = 0; cnt_ar = 0; cnt_b = 0; cnt_r = 0;
      axi.awready = 0; axi.wready = 0; axi.arready = 0;
      axi.bvalid = 0; axi.bresp = 2'b00; axi.rvalid = 0; axi.rresp = 2'b00; axi.rdata = '0;
      forever begin
         @(negedge clk);
         rst_s = rst;
         aw_hs = axi.awvalid && axi.awready;
         w_hs  = axi.wvalid && axi.wready;
         b_hs  = axi.bvalid && axi.bready;
         ar_hs = axi.arvalid && axi.arready;
         r_hs  = axi.rvalid && axi.rready;
         @(posedge clk);
         #1;
         if (rst_s) begin
            axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.bvalid = 0; axi.rvalid = 0;
            got_aw = 0; got_w = 0; got_ar = 0;
            cnt_aw = 0; cnt_w = 0; cnt_ar = 0; cnt_b = 0; cnt_r = 0;
         end else begin
            if (aw_hs) begin axi.awready = 0; got_aw = 1; cnt_aw = 0; end
            else if (axi.awvalid && !axi.awready) begin
               if (cnt_aw >= aw_lat) axi.awready = 1; else cnt_aw++;
            end
            if (w_hs) begin axi.wready = 0; got_w = 1; cnt_w = 0; end
            else if (axi.wvalid && !axi.wready) begin
               if (cnt_w >= w_lat) axi.wready = 1; else cnt_w++;
            end
            if (ar_hs) begin axi.arready = 0; got_ar = 1; cnt_ar = 0; end
            else if (axi.arvalid && !axi.arready) begin
               if (cnt_ar >= ar_lat) axi.arready = 1; else cnt_ar++;
            end
            if (b_hs) axi.bvalid = 0;
            else if (got_aw && got_w && !axi.bvalid) begin
               if (cnt_b >= b_lat) begin
                  axi.bvalid = 1; axi.bresp = cfg_bresp; got_aw = 0; got_w = 0; cnt_b = 0;
               end else cnt_b++;
            end
            if (r_hs) axi.rvalid = 0;
            else if (got_ar && !axi.rvalid) begin
               if (cnt_r >= r_lat) begin
                  axi.rvalid = 1; axi.rdata = cfg_rdata; axi.rresp = cfg_rresp; got_ar = 0; cnt_r = 0;
               end else cnt_r++;
            end
         end
      end
   end

   // ---------------- host tx sink ----------------
   initial begin
      tx_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (tx_stall_left > 0) begin
            tx_ready_i = 1'b0;
            tx_stall_left--;
         end else begin
            tx_ready_i = 1'b1;
         end
      end
   end

   // ---------------- compare process ----------------
   initial begin
      logic prev_stall, tx_follow, split_follow, busy;
      logic [7:0] prev_data;
      prev_stall = 0; tx_follow = 0; split_follow = 0; prev_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 0; tx_follow = 0; split_follow = 0;
         end else begin
            busy = axi.awvalid | axi.wvalid | axi.arvalid | axi.bready | axi.rready | tx_valid_o;
            chk("rx_ready_only_when_free", rx_ready_o, !busy);
            if (expect_bus == 1) chk("cmd_to_aw_w", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b110);
            if (expect_bus == 2) chk("cmd_to_ar", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b001);
            expect_bus = 0;
            if (tx_follow) chk("resp_to_tx_valid", tx_valid_o, 1'b1);
            tx_follow = 0;
            if (prev_stall) begin
               chk("tx_hold_valid", tx_valid_o, 1'b1);
               chk("tx_hold_data", tx_data_o, prev_data);
            end
            if (split_follow) chk("split_aw_low_w_high", {axi.awvalid, axi.wvalid}, 2'b01);
            split_follow = 0;
            if (axi.awvalid || axi.wvalid || axi.arvalid) valid_cycles++;
            if (axi.awvalid && axi.awready) begin
               n_aw++;
               last_awaddr = axi.awaddr;
               chk("aw_expected", exp_aw_q.size() > 0, 1'b1);
               if (exp_aw_q.size() > 0) chk("awaddr", axi.awaddr, exp_aw_q.pop_front());
               chk("awprot", axi.awprot, 3'b000);
               if (axi.wvalid && !axi.wready) split_follow = 1;
            end
            if (axi.wvalid && axi.wready) begin
               n_w++;
               last_wdata = axi.wdata;
               chk("w_expected", exp_w_q.size() > 0, 1'b1);
               if (exp_w_q.size() > 0) chk("wdata", axi.wdata, exp_w_q.pop_front());
               chk("wstrb", axi.wstrb, 4'hF);
            end
            if (axi.arvalid && axi.arready) begin
               n_ar++;
               chk("ar_expected", exp_ar_q.size() > 0, 1'b1);
               if (exp_ar_q.size() > 0) chk("araddr", axi.araddr, exp_ar_q.pop_front());
               chk("arprot", axi.arprot, 3'b000);
            end
            if ((axi.bvalid && axi.bready) || (axi.rvalid && axi.rready)) tx_follow = 1;
            if (tx_valid_o && tx_ready_i) begin
               got_tx_q.push_back(tx_data_o);
               chk("tx_expected", exp_tx_q.size() > 0, 1'b1);
               if (exp_tx_q.size() > 0) chk("tx_byte", tx_data_o, exp_tx_q.pop_front());
            end
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_data  = tx_data_o;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b);
      int n;
      logic acc;
      n = 0;
      acc = 0;
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = rx_ready_o;
         @(posedge clk);
         #1;
         n++;
      end
      chk("rx_byte_accepted", acc, 1'b1);
      rx_valid_i = 1'b0;
   endtask

   task automatic model_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
      if (op == 8'h01) begin
         exp_aw_q.push_back(addr);
         exp_w_q.push_back(data);
         exp_tx_q.push_back({6'b0, cfg_bresp});
      end else if (op == 8'h02) begin
         exp_ar_q.push_back(addr);
         exp_tx_q.push_back({6'b0, cfg_rresp});
         for (int i = 0; i < 4; i++) exp_tx_q.push_back(cfg_rdata[8*i +: 8]);
      end else begin
         exp_tx_q.push_back(8'hFF);
      end
   endtask

   task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
      send_byte(op);
      if (op == 8'h01 || op == 8'h02) begin
         for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
         if (op == 8'h01) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
         expect_bus = (op == 8'h01) ? 1 : 2;
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_tx_q.size() != 0 || dbg_state != HOST_IDLE) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("cmd_completed", (exp_tx_q.size() == 0) && (dbg_state == HOST_IDLE), 1'b1);
   endtask

   task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input int stall_after, input logic noise);
      int a0, w0, r0, v0, n;
      a0 = n_aw; w0 = n_w; r0 = n_ar; v0 = valid_cycles;
      got_tx_q.delete();
      model_cmd(op, addr, data);
      send_cmd(op, addr, data);
      if (noise) begin
         rx_data_i  = 8'h01;
         rx_valid_i = 1'b1;
         repeat (3) begin @(posedge clk); #1; end
         rx_valid_i = 1'b0;
      end
      if (stall_after >= 0) begin
         n = 0;
         while (got_tx_q.size() < stall_after && n < 500) begin @(negedge clk); n++; end
         tx_stall_left = 5;
      end
      wait_done();
      chk("aw_count", n_aw - a0, (op == 8'h01) ? 1 : 0);
      chk("w_count", n_w - w0, (op == 8'h01) ? 1 : 0);
      chk("ar_count", n_ar - r0, (op == 8'h02) ? 1 : 0);
      if (op != 8'h01 && op != 8'h02) chk("badop_no_axi_valid", valid_cycles - v0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_state", dbg_state, HOST_IDLE);
      chk("reset_rx_ready", rx_ready_o, 1'b1);
      chk("reset_tx_valid", tx_valid_o, 1'b0);
      chk("reset_axi_ctrl", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
      chk("reset_addr", axi.awaddr, 32'h0);
      chk("reset_wdata", axi.wdata, 32'h0);

      // write, OKAY, AW and W taken together
      aw_lat = 0; w_lat = 0; b_lat = 0; cfg_bresp = 2'b00;
      run_cmd(8'h01, 32'h0000_0010, 32'hDEAD_BEEF, -1, 1'b0);
      chk("pin_awaddr", last_awaddr, 32'h0000_0010);
      chk("pin_wdata", last_wdata, 32'hDEAD_BEEF);
      chk("pin_write_resp", (got_tx_q.size() == 1) ? got_tx_q[0] : 8'hXX, 8'h00);

      // read, data one cycle after AR
      r_lat = 1; cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b00;
      run_cmd(8'h02, 32'h0000_0010, 32'h0, -1, 1'b0);
      chk("pin_read_bytes", (got_tx_q.size() == 5) ?
          {got_tx_q[4], got_tx_q[3], got_tx_q[2], got_tx_q[1], got_tx_q[0]} : 40'hX, 40'hDEAD_BEEF_00);

      // unknown opcode
      run_cmd(8'h7A, 32'h0, 32'h0, -1, 1'b0);
      chk("pin_badop", (got_tx_q.size() == 1) ? got_tx_q[0] : 8'hXX, 8'hFF);

      // read with host stalling mid-response
      cfg_rdata = 32'h1234_5678; r_lat = 2;
      run_cmd(8'h02, 32'h8000_0004, 32'h0, 2, 1'b0);
      chk("stall_byte_count", got_tx_q.size(), 5);

      // write, SLVERR
      cfg_bresp = 2'b10; b_lat = 2;
      run_cmd(8'h01, 32'h0000_0040, 32'h0102_0304, -1, 1'b0);
      chk("pin_slverr", (got_tx_q.size() == 1) ? got_tx_q[0] : 8'hXX, 8'h02);

      // split: AW one cycle before W, then W before AW
      cfg_bresp = 2'b00; b_lat = 0; aw_lat = 0; w_lat = 1;
      run_cmd(8'h01, 32'h0000_0020, 32'h0BAD_F00D, -1, 1'b0);
      aw_lat = 2; w_lat = 0;
      run_cmd(8'h01, 32'hFFFF_FFFC, 32'hCAFE_0001, -1, 1'b0);
      aw_lat = 0;

      // read with DECERR while the host offers bytes during the bus phase
      r_lat = 4; cfg_rresp = 2'b11; cfg_rdata = 32'hA5A5_5A5A;
      run_cmd(8'h02, 32'h0000_0100, 32'h0, -1, 1'b1);

      // reset while waiting for R
      r_lat = 30; cfg_rresp = 2'b00;
      exp_ar_q.push_back(32'h0000_0200);
      send_cmd(8'h02, 32'h0000_0200, 32'h0);
      for (int n = 0; n < 50 && dbg_state != AXI_R; n++) begin @(posedge clk); #1; end
      chk("reached_axi_r", dbg_state, AXI_R);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_mid_state", dbg_state, HOST_IDLE);
      chk("rst_mid_rready", axi.rready, 1'b0);
      chk("rst_mid_rx_ready", rx_ready_o, 1'b1);
      chk("rst_mid_tx_valid", tx_valid_o, 1'b0);
      exp_tx_q.delete();
      exp_ar_q.delete();

      r_lat = 1; cfg_rdata = 32'h0F1E_2D3C;
      run_cmd(8'h02, 32'h0000_0010, 32'h0, -1, 1'b0);
      chk("pin_after_reset_read", (got_tx_q.size() == 5) ?
          {got_tx_q[4], got_tx_q[3], got_tx_q[2], got_tx_q[1], got_tx_q[0]} : 40'hX, 40'h0F1E_2D3C_00);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
